// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the kitchen-timer controller.
//  state_t  : FSM encoding (also exported on o_state)
//  bcd4_t   : MM:SS value as four packed BCD digits
//  KEY_*    : default keypad codes for clear and start/pause
//  BLANK    : BCD code that renders an unused display digit dark
package timer_ctrl_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned KEY_W   = 5;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned DISP_W  = 32;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_ALARM = 3'd4
   } state_t;

   typedef struct packed {
      logic [DIGIT_W-1:0] m1;
      logic [DIGIT_W-1:0] m0;
      logic [DIGIT_W-1:0] s1;
      logic [DIGIT_W-1:0] s0;
   } bcd4_t;

   localparam logic [KEY_W-1:0]   KEY_CLR_DEF = 5'd10;
   localparam logic [KEY_W-1:0]   KEY_GO_DEF  = 5'd11;
   localparam logic [KEY_W-1:0]   KEY_MAX_DIG = 5'd9;
   localparam logic [DIGIT_W-1:0] BLANK       = 4'hF;
   localparam bcd4_t              BCD_ZERO    = '0;

endpackage

// File: rtl/timer_ctrl_if.sv
// Keypad / switch / display bundle between the timer controller and its neighbours.
//  master : keypad decoder, start switch and 1 kHz source side (drives the i_* signals)
//  slave  : timer_ctrl side (drives the o_* signals)
interface timer_ctrl_if;
   import timer_ctrl_pkg::*;

   logic               i_pls_1k;
   logic               i_key_valid;
   logic [KEY_W-1:0]   i_bcd_data;
   logic               i_start_sw;
   logic [DISP_W-1:0]  o_bcd8d;
   logic               o_fin;
   logic               o_run;
   logic               o_err;
   logic [STATE_W-1:0] o_state;

   modport master (
      output i_pls_1k, i_key_valid, i_bcd_data, i_start_sw,
      input  o_bcd8d, o_fin, o_run, o_err, o_state
   );

   modport slave (
      input  i_pls_1k, i_key_valid, i_bcd_data, i_start_sw,
      output o_bcd8d, o_fin, o_run, o_err, o_state
   );

endinterface

// File: rtl/timer_ctrl_bcd_dn4.sv
// Combinational 4-digit MM:SS BCD decrement with zero flag on the result.
//  val    : current value
//  dn_c   : val minus one second (seconds tens borrow at 0 -> 5)
//  zero_c : dn_c is 00:00
// Decrementing 00:00 wraps to 99:59; callers never do that.
module timer_ctrl_bcd_dn4
   import timer_ctrl_pkg::*;
(
   input  bcd4_t val,
   output bcd4_t dn_c,
   output logic  zero_c
);

   // Ripple borrow through the four digits
   always_comb begin
      dn_c = val;
      if (val.s0 != 4'd0) begin
         dn_c.s0 = val.s0 - 4'd1;
      end else begin
         dn_c.s0 = 4'd9;
         if (val.s1 != 4'd0) begin
            dn_c.s1 = val.s1 - 4'd1;
         end else begin
            dn_c.s1 = 4'd5;
            if (val.m0 != 4'd0) begin
               dn_c.m0 = val.m0 - 4'd1;
            end else begin
               dn_c.m0 = 4'd9;
               dn_c.m1 = (val.m1 != 4'd0) ? val.m1 - 4'd1 : 4'd9;
            end
         end
      end
   end

   assign zero_c = (dn_c == BCD_ZERO);

endmodule

// File: rtl/timer_ctrl.sv
// Kitchen-timer sequencing controller: keypad entry of MM:SS, countdown from the
// 1 kHz strobe, pause/resume, and a timed alarm request.
//  i_clk, i_rst : clock and synchronous active-high reset
//  bus.i_*      : 1 kHz strobe, keypad strobe/code, debounced start switch
//  bus.o_bcd8d  : {4 blank digits, m1, m0, s1, s0}
//  bus.o_fin    : alarm active
//  bus.o_run    : counting down
//  bus.o_err    : one-cycle pulse when a start is rejected
//  bus.o_state  : FSM state
// TICK_DIV and ALARM_MS must be at least 2.
module timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int unsigned      TICK_DIV = 1000,
   parameter int unsigned      ALARM_MS = 5000,
   parameter logic [KEY_W-1:0] KEY_CLR  = KEY_CLR_DEF,
   parameter logic [KEY_W-1:0] KEY_GO   = KEY_GO_DEF
)(
   input logic          i_clk,
   input logic          i_rst,
   timer_ctrl_if.slave  bus
);

   localparam int unsigned      SUB_W    = $clog2(TICK_DIV);
   localparam int unsigned      ALM_W    = $clog2(ALARM_MS);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_DIV - 1);
   localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_MS - 1);

   state_t             state;
   bcd4_t              val;
   logic [SUB_W-1:0]   sub;
   logic [ALM_W-1:0]   alm;
   logic               sw_q;
   logic               run_q;
   logic               fin_q;
   logic               err_q;

   logic               go_c;
   logic               clr_c;
   logic               digit_c;
   logic               bad_start_c;
   logic [DIGIT_W-1:0] digit_val_c;
   bcd4_t              dn_c;
   logic               dn_zero_c;

   // Switch edge and key code decode; switch edge and KEY_GO merge into one GO
   always_comb begin
      go_c        = (bus.i_start_sw & ~sw_q)
                  | (bus.i_key_valid && (bus.i_bcd_data == KEY_GO));
      clr_c       = bus.i_key_valid && (bus.i_bcd_data == KEY_CLR);
      digit_c     = bus.i_key_valid && (bus.i_bcd_data <= KEY_MAX_DIG);
      digit_val_c = bus.i_bcd_data[DIGIT_W-1:0];
      bad_start_c = (val == BCD_ZERO) || (val.s1 > 4'd5);
   end

   timer_ctrl_bcd_dn4 u_dn (
      .val    (val),
      .dn_c   (dn_c),
      .zero_c (dn_zero_c)
   );

   // FSM with counters and registered status flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
         val   <= BCD_ZERO;
         sub   <= '0;
         alm   <= '0;
         sw_q  <= 1'b0;
         run_q <= 1'b0;
         fin_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         sw_q  <= bus.i_start_sw;
         err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (digit_c) begin
                  state <= ST_ENTRY;
                  val   <= {4'h0, 4'h0, 4'h0, digit_val_c};
               end
            end
            ST_ENTRY: begin
               if (clr_c) begin
                  state <= ST_IDLE;
                  val   <= BCD_ZERO;
               end else if (go_c) begin
                  if (bad_start_c) begin
                     err_q <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     sub   <= '0;
                     run_q <= 1'b1;
                  end
               end else if (digit_c) begin
                  val <= {val.m0, val.s1, val.s0, digit_val_c};
               end
            end
            ST_RUN: begin
               // Key events outrank a coincident tick, which is dropped
               if (clr_c) begin
                  state <= ST_IDLE;
                  val   <= BCD_ZERO;
                  run_q <= 1'b0;
               end else if (go_c) begin
                  state <= ST_PAUSE;
                  run_q <= 1'b0;
               end else if (bus.i_pls_1k) begin
                  if (sub >= SUB_LAST) begin
                     sub <= '0;
                     val <= dn_c;
                     if (dn_zero_c) begin
                        state <= ST_ALARM;
                        alm   <= '0;
                        run_q <= 1'b0;
                        fin_q <= 1'b1;
                     end
                  end else begin
                     sub <= sub + SUB_W'(1);
                  end
               end
            end
            ST_PAUSE: begin
               if (clr_c) begin
                  state <= ST_IDLE;
                  val   <= BCD_ZERO;
               end else if (go_c) begin
                  state <= ST_RUN;
                  run_q <= 1'b1;
               end
            end
            ST_ALARM: begin
               // Any key or GO only cancels the alarm
               if (go_c || bus.i_key_valid || (bus.i_pls_1k && (alm >= ALM_LAST))) begin
                  state <= ST_IDLE;
                  val   <= BCD_ZERO;
                  fin_q <= 1'b0;
               end else if (bus.i_pls_1k) begin
                  alm <= alm + ALM_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               val   <= BCD_ZERO;
               run_q <= 1'b0;
               fin_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_state = state;
   assign bus.o_bcd8d = {BLANK, BLANK, BLANK, BLANK, val};
   assign bus.o_run   = run_q;
   assign bus.o_fin   = fin_q;
   assign bus.o_err   = err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=10, ALARM_MS=20.
module tb_timer_ctrl;

   localparam logic [4:0] K_CLR = 5'd10;
   localparam logic [4:0] K_GO  = 5'd11;
   localparam int unsigned S_IDLE  = 0;
   localparam int unsigned S_ENTRY = 1;
   localparam int unsigned S_RUN   = 2;
   localparam int unsigned S_PAUSE = 3;
   localparam int unsigned S_ALARM = 4;

   logic clk;
   logic rst;
   int   nvec;
   int   nmis;

   timer_ctrl_if bus ();

   timer_ctrl #(
      .TICK_DIV (10),
      .ALARM_MS (20)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic key(input logic [4:0] code);
      bus.i_key_valid = 1'b1;
      bus.i_bcd_data  = code;
      @(negedge clk);
      bus.i_key_valid = 1'b0;
      bus.i_bcd_data  = 5'd0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_pls_1k = 1'b1;
         @(negedge clk);
         bus.i_pls_1k = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      nvec = 0;
      nmis = 0;
      rst  = 1'b1;
      bus.i_pls_1k    = 1'b0;
      bus.i_key_valid = 1'b0;
      bus.i_bcd_data  = 5'd0;
      bus.i_start_sw  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_state", 32'(bus.o_state), S_IDLE);
      chk("rst_disp",  bus.o_bcd8d, 32'hFFFF_0000);
      chk("rst_flags", {29'd0, bus.o_fin, bus.o_run, bus.o_err}, 32'd0);

      // Entry shifting, oldest digit dropped, then clear
      key(5'd1);
      chk("entry_first", bus.o_bcd8d, 32'hFFFF_0001);
      key(5'd2); key(5'd3); key(5'd4); key(5'd5);
      chk("entry_disp",  bus.o_bcd8d, 32'hFFFF_2345);
      chk("entry_state", 32'(bus.o_state), S_ENTRY);
      key(K_CLR);
      chk("clr_disp",  bus.o_bcd8d, 32'hFFFF_0000);
      chk("clr_state", 32'(bus.o_state), S_IDLE);

      // 01:00 started by switch edge, count down into alarm
      key(5'd0); key(5'd1); key(5'd0); key(5'd0);
      chk("e0100_disp", bus.o_bcd8d, 32'hFFFF_0100);
      bus.i_start_sw = 1'b1;
      @(negedge clk);
      chk("sw_run_state", 32'(bus.o_state), S_RUN);
      chk("sw_run_flag",  32'(bus.o_run), 32'd1);
      pulses(10);
      chk("borrow_0059", bus.o_bcd8d, 32'hFFFF_0059);
      pulses(589);
      chk("pre_alarm_disp",  bus.o_bcd8d, 32'hFFFF_0001);
      chk("pre_alarm_state", 32'(bus.o_state), S_RUN);
      pulses(1);
      chk("alarm_state", 32'(bus.o_state), S_ALARM);
      chk("alarm_fin",   32'(bus.o_fin), 32'd1);
      chk("alarm_run",   32'(bus.o_run), 32'd0);
      chk("alarm_disp",  bus.o_bcd8d, 32'hFFFF_0000);
      bus.i_start_sw = 1'b0;

      // Alarm times out after 20 pulses
      pulses(19);
      chk("alarm_hold", 32'(bus.o_fin), 32'd1);
      pulses(1);
      chk("alarm_to_state", 32'(bus.o_state), S_IDLE);
      chk("alarm_to_fin",   32'(bus.o_fin), 32'd0);

      // 00:70 rejected on GO
      key(5'd0); key(5'd0); key(5'd7); key(5'd0);
      key(K_GO);
      chk("err_pulse", 32'(bus.o_err), 32'd1);
      chk("err_state", 32'(bus.o_state), S_ENTRY);
      chk("err_disp",  bus.o_bcd8d, 32'hFFFF_0070);
      @(negedge clk);
      chk("err_once", 32'(bus.o_err), 32'd0);
      key(K_CLR);

      // Pause freezes the sub-counter without clearing it
      key(5'd5);
      key(K_GO);
      chk("p_run", 32'(bus.o_state), S_RUN);
      pulses(4);
      key(K_GO);
      chk("p_state", 32'(bus.o_state), S_PAUSE);
      chk("p_run_flag", 32'(bus.o_run), 32'd0);
      pulses(50);
      chk("p_frozen", bus.o_bcd8d, 32'hFFFF_0005);
      key(K_GO);
      chk("p_resume", 32'(bus.o_state), S_RUN);
      pulses(5);
      chk("p_5more", bus.o_bcd8d, 32'hFFFF_0005);
      pulses(1);
      chk("p_6more", bus.o_bcd8d, 32'hFFFF_0004);
      key(K_CLR);
      chk("run_clr", 32'(bus.o_state), S_IDLE);

      // Alarm cancelled by a digit key, which does not start a new entry
      key(5'd1);
      key(K_GO);
      pulses(10);
      chk("a2_state", 32'(bus.o_state), S_ALARM);
      pulses(2);
      key(5'd3);
      chk("a2_cancel", 32'(bus.o_state), S_IDLE);
      chk("a2_fin",    32'(bus.o_fin), 32'd0);
      chk("a2_disp",   bus.o_bcd8d, 32'hFFFF_0000);

      // Reset mid-run
      key(5'd3); key(5'd0);
      key(K_GO);
      pulses(3);
      chk("r_disp", bus.o_bcd8d, 32'hFFFF_0030);
      rst = 1'b1;
      @(negedge clk);
      chk("r_state", 32'(bus.o_state), S_IDLE);
      chk("r_disp0", bus.o_bcd8d, 32'hFFFF_0000);
      chk("r_run",   32'(bus.o_run), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Switch edge and KEY_GO in one cycle are a single GO
      key(5'd1); key(5'd0);
      bus.i_start_sw  = 1'b1;
      bus.i_key_valid = 1'b1;
      bus.i_bcd_data  = K_GO;
      @(negedge clk);
      bus.i_key_valid = 1'b0;
      bus.i_bcd_data  = 5'd0;
      chk("dual_go", 32'(bus.o_state), S_RUN);
      @(negedge clk);
      chk("dual_go_hold", 32'(bus.o_state), S_RUN);

      // A tick coincident with GO in RUN is discarded
      pulses(3);
      bus.i_pls_1k    = 1'b1;
      bus.i_key_valid = 1'b1;
      bus.i_bcd_data  = K_GO;
      @(negedge clk);
      bus.i_pls_1k    = 1'b0;
      bus.i_key_valid = 1'b0;
      bus.i_bcd_data  = 5'd0;
      chk("tick_go_pause", 32'(bus.o_state), S_PAUSE);
      key(K_GO);
      pulses(6);
      chk("tick_drop_hold", bus.o_bcd8d, 32'hFFFF_0010);
      pulses(1);
      chk("tick_drop_dec", bus.o_bcd8d, 32'hFFFF_0009);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
